// File: rtl/acumulador_punto_fijo.sv
// Block accumulator for sign-magnitude Q16.15 samples.
// Sums N_MUESTRAS samples, emits one saturated sign-magnitude result.
module acumulador_punto_fijo #(
  parameter int N_MUESTRAS = 8,
  parameter int ACC_W      = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        overflow
);

  typedef enum logic {ACUM, SALIDA} estado_t;

  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = -MAXV;
  localparam logic [7:0] ULTIMO = 8'(N_MUESTRAS - 1);

  estado_t r_estado;
  estado_t w_estado_sig;

  logic signed [ACC_W-1:0] r_acc;
  logic [7:0]              r_cnt;
  logic [31:0]             r_out_data;
  logic                    r_overflow;

  logic signed [ACC_W-1:0] w_mag;
  logic signed [ACC_W-1:0] w_conv;
  logic signed [ACC_W-1:0] w_suma;
  logic signed [ACC_W-1:0] w_abs;
  logic                    w_sat_pos;
  logic                    w_sat_neg;
  logic                    w_neg;
  logic [31:0]             w_res;
  logic                    w_hs_in;
  logic                    w_ultima;
  logic                    w_hs_out;

  assign w_mag  = {{(ACC_W-31){1'b0}}, in_data[30:0]};
  assign w_conv = in_data[31] ? -w_mag : w_mag;
  assign w_suma = r_acc + w_conv;
  assign w_abs  = w_suma[ACC_W-1] ? -w_suma : w_suma;

  assign w_sat_pos = w_suma > MAXV;
  assign w_sat_neg = w_suma < MINV;
  // A zero magnitude always gets a positive sign
  assign w_neg = w_suma[ACC_W-1] & (w_abs != '0);

  always_comb begin
    w_res = {w_neg, w_abs[30:0]};
    if (w_sat_pos) w_res = 32'h7FFF_FFFF;
    if (w_sat_neg) w_res = 32'hFFFF_FFFF;
  end

  assign in_ready  = (r_estado == ACUM) & ~rst;
  assign out_valid = (r_estado == SALIDA);
  assign out_data  = r_out_data;
  assign overflow  = r_overflow;

  assign w_hs_in  = in_valid & in_ready;
  assign w_ultima = w_hs_in & (r_cnt == ULTIMO);
  assign w_hs_out = out_valid & out_ready;

  always_comb begin
    w_estado_sig = r_estado;
    unique case (r_estado)
      ACUM:   if (w_ultima) w_estado_sig = SALIDA;
      SALIDA: if (out_ready) w_estado_sig = ACUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado   <= ACUM;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      if (w_hs_in) begin
        r_acc <= w_suma;
        r_cnt <= r_cnt + 8'd1;
        if (w_ultima) begin
          r_out_data <= w_res;
          r_overflow <= w_sat_pos | w_sat_neg;
        end
      end
      if (w_hs_out) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_acumulador_punto_fijo.sv
// Directed bench: N=2 vector table plus N=4 backpressure/reset cases.
module tb_acumulador_punto_fijo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_ov, a_or, a_ovf;
  logic [31:0] a_id, a_od;
  logic        b_iv, b_ir, b_ov, b_or, b_ovf;
  logic [31:0] b_id, b_od;

  acumulador_punto_fijo #(.N_MUESTRAS(2), .ACC_W(40)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .overflow(a_ovf)
  );

  acumulador_punto_fijo #(.N_MUESTRAS(4), .ACC_W(40)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or),
    .out_data(b_od), .overflow(b_ovf)
  );

  int errores = 0;
  int total   = 0;

  task automatic chk(input string nom,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errores++;
      $display("FAIL %s: got %h expected %h", nom, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ovf;
    string       nom;
  } vec_t;

  vec_t tabla[12];

  task automatic bloque2(input vec_t v);
    a_iv = 1'b1;
    a_id = v.a;
    chk({v.nom, "/rdy0"}, 32'(a_ir), 32'd1);
    tick();
    chk({v.nom, "/ov_early"}, 32'(a_ov), 32'd0);
    chk({v.nom, "/rdy1"}, 32'(a_ir), 32'd1);
    a_id = v.b;
    tick();
    a_iv = 1'b0;
    a_id = 32'hDEAD_BEEF;
    chk({v.nom, "/ov"}, 32'(a_ov), 32'd1);
    chk({v.nom, "/data"}, a_od, v.r);
    chk({v.nom, "/ovf"}, 32'(a_ovf), 32'(v.ovf));
    chk({v.nom, "/rdy_sal"}, 32'(a_ir), 32'd0);
    tick();
    chk({v.nom, "/hold"}, a_od, v.r);
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    chk({v.nom, "/ov_fall"}, 32'(a_ov), 32'd0);
    chk({v.nom, "/rdy_back"}, 32'(a_ir), 32'd1);
  endtask

  initial begin
    tabla[0]  = '{32'h0000_C000, 32'h0001_A000,
                  32'h0002_6000, 1'b0, "basic"};
    tabla[1]  = '{32'h0001_8000, 32'h0001_A000,
                  32'h0003_2000, 1'b0, "basic2"};
    tabla[2]  = '{32'h0000_C000, 32'h8001_A000,
                  32'h8000_E000, 1'b0, "mixed"};
    tabla[3]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF,
                  32'h7FFF_FFFF, 1'b1, "sat_pos"};
    tabla[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFF, 1'b1, "sat_neg"};
    tabla[5]  = '{32'h0000_8000, 32'h0000_8000,
                  32'h0001_0000, 1'b0, "after_sat"};
    tabla[6]  = '{32'h0001_8000, 32'h8001_8000,
                  32'h0000_0000, 1'b0, "zero_mix"};
    tabla[7]  = '{32'h8000_0000, 32'h8000_0000,
                  32'h0000_0000, 1'b0, "neg_zero"};
    tabla[8]  = '{32'h7FFF_FFFE, 32'h0000_0001,
                  32'h7FFF_FFFF, 1'b0, "edge_pos"};
    tabla[9]  = '{32'h7FFF_FFFF, 32'h0000_0001,
                  32'h7FFF_FFFF, 1'b1, "over_pos"};
    tabla[10] = '{32'hFFFF_FFFF, 32'h8000_0000,
                  32'hFFFF_FFFF, 1'b0, "edge_neg"};
    tabla[11] = '{32'h8000_0001, 32'h0000_0000,
                  32'h8000_0001, 1'b0, "small_neg"};

    rst  = 1'b1;
    a_iv = 1'b0; a_or = 1'b0; a_id = '0;
    b_iv = 1'b0; b_or = 1'b0; b_id = '0;
    tick();
    tick();
    chk("rst/rdy2", 32'(a_ir), 32'd0);
    chk("rst/rdy4", 32'(b_ir), 32'd0);
    chk("rst/ov", 32'(a_ov), 32'd0);
    chk("rst/data", a_od, 32'd0);
    chk("rst/ovf", 32'(a_ovf), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst/rdy_after", 32'(a_ir), 32'd1);

    for (int i = 0; i < 12; i++) bloque2(tabla[i]);

    // Reset while a result is pending drops it
    a_iv = 1'b1;
    a_id = 32'h0000_8000;
    tick();
    tick();
    a_iv = 1'b0;
    chk("rst_sal/ov_pre", 32'(a_ov), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_sal/rdy", 32'(a_ir), 32'd0);
    chk("rst_sal/ov", 32'(a_ov), 32'd0);
    chk("rst_sal/data", a_od, 32'd0);
    rst = 1'b0;
    tick();
    bloque2(tabla[0]);

    // Backpressure with in_valid held high, N=4
    b_iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_id = 32'((i + 1) * 32'h8000);
      chk("bp/rdy", 32'(b_ir), 32'd1);
      chk("bp/ov_early", 32'(b_ov), 32'd0);
      tick();
    end
    chk("bp/ov", 32'(b_ov), 32'd1);
    chk("bp/data", b_od, 32'h0005_0000);
    chk("bp/ovf", 32'(b_ovf), 32'd0);
    b_id = 32'h7FFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp/hold_ov", 32'(b_ov), 32'd1);
      chk("bp/hold_data", b_od, 32'h0005_0000);
      chk("bp/hold_rdy", 32'(b_ir), 32'd0);
    end
    b_or = 1'b1;
    tick();
    b_or = 1'b0;
    chk("bp/ov_fall", 32'(b_ov), 32'd0);
    for (int i = 0; i < 4; i++) begin
      b_id = 32'h0000_4000;
      chk("bp2/rdy", 32'(b_ir), 32'd1);
      chk("bp2/ov_early", 32'(b_ov), 32'd0);
      tick();
    end
    b_iv = 1'b0;
    chk("bp2/ov", 32'(b_ov), 32'd1);
    chk("bp2/data", b_od, 32'h0001_0000);
    b_or = 1'b1;
    tick();
    b_or = 1'b0;

    // Reset in the middle of a block, N=4
    b_iv = 1'b1;
    b_id = 32'h0000_8000;
    for (int i = 0; i < 3; i++) tick();
    b_iv = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid/rdy_rst", 32'(b_ir), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid/ov_after_rst", 32'(b_ov), 32'd0);
    b_iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("mid/ov_early", 32'(b_ov), 32'd0);
      tick();
    end
    b_iv = 1'b0;
    chk("mid/ov", 32'(b_ov), 32'd1);
    chk("mid/data", b_od, 32'h0002_0000);
    chk("mid/ovf", 32'(b_ovf), 32'd0);
    b_or = 1'b1;
    tick();
    b_or = 1'b0;

    $display("Result: errors=%0d of %0d checks", errores, total);
    $finish;
  end

endmodule
